// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, MIPS opcode/func
// fields, ALU operation codes, next-PC selects and the decoder output bundles.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // One-hot instruction class; all zero for an illegal encoding.
  typedef struct packed {
    logic alu;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
  } icls_t;

  typedef struct packed {
    logic [3:0] aluc;
    logic       shift;
    logic       aluimm;
    logic       sext;
    logic       regrt;
    logic       m2reg;
    logic       jal;
  } ctl_t;

endpackage

// File: rtl/mc_cu_dec.sv
// Combinational op/func decoder: instruction class, illegal flag and the
// datapath controls that do not depend on the FSM state.
module mc_cu_dec
  import mc_cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output icls_t      cls,
  output logic       illegal,
  output ctl_t       ctl
);

  always_comb begin
    cls     = '0;
    ctl     = '0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          FN_ADD: begin cls.alu = 1'b1; ctl.aluc = ALU_ADD; end
          FN_SUB: begin cls.alu = 1'b1; ctl.aluc = ALU_SUB; end
          FN_AND: begin cls.alu = 1'b1; ctl.aluc = ALU_AND; end
          FN_OR:  begin cls.alu = 1'b1; ctl.aluc = ALU_OR;  end
          FN_XOR: begin cls.alu = 1'b1; ctl.aluc = ALU_XOR; end
          FN_SLL: begin cls.alu = 1'b1; ctl.aluc = ALU_SLL; ctl.shift = 1'b1; end
          FN_SRL: begin cls.alu = 1'b1; ctl.aluc = ALU_SRL; ctl.shift = 1'b1; end
          FN_SRA: begin cls.alu = 1'b1; ctl.aluc = ALU_SRA; ctl.shift = 1'b1; end
          FN_JR:  cls.jr = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        cls.alu = 1'b1; ctl.aluc = ALU_ADD;
        ctl.aluimm = 1'b1; ctl.sext = 1'b1; ctl.regrt = 1'b1;
      end
      OP_ANDI: begin cls.alu = 1'b1; ctl.aluc = ALU_AND; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; end
      OP_ORI:  begin cls.alu = 1'b1; ctl.aluc = ALU_OR;  ctl.aluimm = 1'b1; ctl.regrt = 1'b1; end
      OP_XORI: begin cls.alu = 1'b1; ctl.aluc = ALU_XOR; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; end
      OP_LUI:  begin cls.alu = 1'b1; ctl.aluc = ALU_LUI; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; end
      OP_LW: begin
        cls.lw = 1'b1; ctl.aluc = ALU_ADD;
        ctl.aluimm = 1'b1; ctl.sext = 1'b1; ctl.regrt = 1'b1; ctl.m2reg = 1'b1;
      end
      OP_SW:  begin cls.sw = 1'b1; ctl.aluc = ALU_ADD; ctl.aluimm = 1'b1; ctl.sext = 1'b1; end
      // Branches compare by subtraction; offset is sign-extended.
      OP_BEQ: begin cls.beq = 1'b1; ctl.aluc = ALU_SUB; ctl.sext = 1'b1; end
      OP_BNE: begin cls.bne = 1'b1; ctl.aluc = ALU_SUB; ctl.sext = 1'b1; end
      OP_J:   cls.j = 1'b1;
      OP_JAL: begin cls.jal = 1'b1; ctl.jal = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// Multicycle control FSM (IF/ID/EXE/MEM/WB/HALT) sharing one memory port,
// with a bounded memory-ready wait, illegal-opcode trap and retire counter.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MAX_WAIT      = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_rdy,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             wreg,
  output logic             iord,
  output logic [1:0]       pcsource,
  output logic [3:0]       aluc,
  output logic             shift,
  output logic             aluimm,
  output logic             sext,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] icount
);

  localparam int          WW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

  state_t        st, nxt;
  logic [WW-1:0] wcnt;
  icls_t         cls;
  ctl_t          ctl;
  logic          dec_ill, rdy, set_ill, set_berr, retire;

  mc_cu_dec u_dec (
    .op      (op),
    .func    (func),
    .cls     (cls),
    .illegal (dec_ill),
    .ctl     (ctl)
  );

  assign rdy = MEM_HANDSHAKE ? mem_rdy : 1'b1;
  assign {aluc, shift, aluimm, sext, regrt, m2reg, jal} = ctl;
  assign state  = st;
  assign halted = (st == S_HALT);

  always_comb begin
    nxt      = st;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    pcsource = PCS_PC4;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    case (st)
      S_IF: begin
        mem_rd = 1'b1;
        if (rdy) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = S_ID;
        end else if (wcnt == WLAST) begin
          set_berr = 1'b1;
          nxt      = S_HALT;
        end
      end
      S_ID: begin
        if (dec_ill) begin
          set_ill = 1'b1;
          nxt     = S_HALT;
        end else if (cls.j || cls.jal) begin
          pc_wr    = 1'b1;
          pcsource = PCS_JMP;
          wreg     = cls.jal;
          nxt      = S_IF;
        end else if (cls.jr) begin
          pc_wr    = 1'b1;
          pcsource = PCS_RS;
          nxt      = S_IF;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (cls.beq || cls.bne) begin
          pc_wr    = (cls.beq & z) | (cls.bne & ~z);
          pcsource = PCS_BR;
          nxt      = S_IF;
        end else if (cls.lw || cls.sw) begin
          nxt = S_MEM;
        end else if (cls.alu) begin
          nxt = S_WB;
        end else begin
          nxt = S_HALT;  // op changed after ID; not a decodable path
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = cls.lw;
        mem_wr = cls.sw;
        if (rdy) begin
          nxt = cls.lw ? S_WB : S_IF;
        end else if (wcnt == WLAST) begin
          set_berr = 1'b1;
          nxt      = S_HALT;
        end
      end
      S_WB: begin
        wreg = 1'b1;
        nxt  = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  assign retire = (nxt == S_IF) && (st != S_IF);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st      <= S_IF;
      wcnt    <= '0;
      icount  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      st <= nxt;
      // Any state change clears the count, which covers every IF/MEM entry.
      if (nxt != st)
        wcnt <= '0;
      else if (!rdy && (st == S_IF || st == S_MEM))
        wcnt <= wcnt + WW'(1);
      if (retire)
        icount <= icount + CNT_W'(1);
      if (set_ill)
        illegal <= 1'b1;
      if (set_berr)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: the stimulus queues a hand-computed expected
// observation per cycle, and a negedge monitor pops and compares it.
module tb_mc_cu;

  localparam logic [2:0] T_IF = 3'd0, T_ID = 3'd1, T_EXE = 3'd2,
                         T_MEM = 3'd3, T_WB = 3'd4, T_HALT = 3'd5;
  // strobe byte: {pc_wr, ir_wr, mem_rd, mem_wr, wreg, iord, pcsource[1:0]}
  localparam logic [7:0] SB_IFR = 8'hE0, SB_IFW = 8'h20, SB_0 = 8'h00,
                         SB_J = 8'h83, SB_JAL = 8'h8B, SB_JR = 8'h82,
                         SB_BT = 8'h81, SB_BN = 8'h01, SB_LW = 8'h24,
                         SB_SW = 8'h14, SB_WB = 8'h08;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101, O_J = 6'b000010,
                         O_JAL = 6'b000011, O_ORI = 6'b001101, O_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000, F_SRA = 6'b000011;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [7:0]  sb;
    logic [2:0]  fl;   // {halted, illegal, bus_err}
    logic [31:0] ic;
    bit          dchk;
    logic [9:0]  dec;  // {aluc, shift, aluimm, sext, regrt, m2reg, jal}
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT 0: handshake on, MAX_WAIT=4, 32-bit counter
  logic        rn0, rdy0, z0;
  logic [5:0]  op0, f0;
  logic        pc_wr0, ir_wr0, mem_rd0, mem_wr0, wreg0, iord0;
  logic [1:0]  pcs0;
  logic [3:0]  aluc0;
  logic        shift0, aluimm0, sext0, regrt0, m2reg0, jal0;
  logic [2:0]  state0;
  logic        halted0, illegal0, bus_err0;
  logic [31:0] icount0;

  // DUT 1: handshake off, mem_rdy held low, 4-bit counter
  logic        rn1, z1;
  logic        rdy1 = 1'b0;
  logic [5:0]  op1, f1;
  logic        pc_wr1, ir_wr1, mem_rd1, mem_wr1, wreg1, iord1;
  logic [1:0]  pcs1;
  logic [3:0]  aluc1;
  logic        shift1, aluimm1, sext1, regrt1, m2reg1, jal1;
  logic [2:0]  state1;
  logic        halted1, illegal1, bus_err1;
  logic [3:0]  icount1;

  mc_cu #(.MEM_HANDSHAKE(1'b1), .MAX_WAIT(4), .CNT_W(32)) u0 (
    .clock(clock), .resetn(rn0), .op(op0), .func(f0), .z(z0), .mem_rdy(rdy0),
    .pc_wr(pc_wr0), .ir_wr(ir_wr0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
    .wreg(wreg0), .iord(iord0), .pcsource(pcs0), .aluc(aluc0), .shift(shift0),
    .aluimm(aluimm0), .sext(sext0), .regrt(regrt0), .m2reg(m2reg0), .jal(jal0),
    .state(state0), .halted(halted0), .illegal(illegal0), .bus_err(bus_err0),
    .icount(icount0)
  );

  mc_cu #(.MEM_HANDSHAKE(1'b0), .MAX_WAIT(4), .CNT_W(4)) u1 (
    .clock(clock), .resetn(rn1), .op(op1), .func(f1), .z(z1), .mem_rdy(rdy1),
    .pc_wr(pc_wr1), .ir_wr(ir_wr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
    .wreg(wreg1), .iord(iord1), .pcsource(pcs1), .aluc(aluc1), .shift(shift1),
    .aluimm(aluimm1), .sext(sext1), .regrt(regrt1), .m2reg(m2reg1), .jal(jal1),
    .state(state1), .halted(halted1), .illegal(illegal1), .bus_err(bus_err1),
    .icount(icount1)
  );

  exp_t q0[$], q1[$];
  int total = 0, bad = 0;

  function automatic exp_t ex(string t, logic [2:0] s, logic [7:0] b,
                              logic [2:0] fl, logic [31:0] ic);
    exp_t e;
    e.tag = t; e.st = s; e.sb = b; e.fl = fl; e.ic = ic; e.dchk = 1'b0; e.dec = '0;
    return e;
  endfunction

  function automatic exp_t exd(exp_t e, logic [9:0] d);
    exp_t r;
    r = e; r.dchk = 1'b1; r.dec = d;
    return r;
  endfunction

  task automatic check(input exp_t e, input logic [2:0] st, input logic [7:0] sb,
                       input logic [2:0] fl, input logic [31:0] ic, input logic [9:0] dec);
    total++;
    if (st !== e.st || sb !== e.sb || fl !== e.fl || ic !== e.ic ||
        (e.dchk && dec !== e.dec)) begin
      bad++;
      $display("FAIL %s: got st=%0d sb=%h fl=%b ic=%0d dec=%b, want st=%0d sb=%h fl=%b ic=%0d dec=%b",
               e.tag, st, sb, fl, ic, dec, e.st, e.sb, e.fl, e.ic, e.dec);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check(e, state0, {pc_wr0, ir_wr0, mem_rd0, mem_wr0, wreg0, iord0, pcs0},
            {halted0, illegal0, bus_err0}, icount0,
            {aluc0, shift0, aluimm0, sext0, regrt0, m2reg0, jal0});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check(e, state1, {pc_wr1, ir_wr1, mem_rd1, mem_wr1, wreg1, iord1, pcs1},
            {halted1, illegal1, bus_err1}, {28'd0, icount1},
            {aluc1, shift1, aluimm1, sext1, regrt1, m2reg1, jal1});
    end
  end

  // Drive one cycle of inputs on DUT d and queue what it should show this cycle.
  task automatic cyc(input int d, input logic rn, input logic rdy, input logic zz,
                     input logic [5:0] o, input logic [5:0] f, input exp_t e);
    if (d == 0) begin
      rn0 = rn; rdy0 = rdy; z0 = zz; op0 = o; f0 = f; q0.push_back(e);
    end else begin
      rn1 = rn; z1 = zz; op1 = o; f1 = f; q1.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    rn0 = 1'b0; rdy0 = 1'b0; z0 = 1'b0; op0 = O_R; f0 = F_ADD;
    rn1 = 1'b0; z1 = 1'b0; op1 = O_SW; f1 = 6'd0;
    @(posedge clock); #1;

    cyc(0, 0, 0, 0, O_R, F_ADD, ex("reset", T_IF, SB_IFW, 3'b000, 0));
    // add, zero wait
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("add_if",  T_IF,  SB_IFR, 3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("add_id",  T_ID,  SB_0,   3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, exd(ex("add_exe", T_EXE, SB_0, 3'b000, 0), 10'b0000_000000));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("add_wb",  T_WB,  SB_WB,  3'b000, 0));
    // lw with two MEM wait cycles
    cyc(0, 1, 1, 0, O_LW, 6'd0, ex("lw_if",   T_IF,  SB_IFR, 3'b000, 1));
    cyc(0, 1, 1, 0, O_LW, 6'd0, ex("lw_id",   T_ID,  SB_0,   3'b000, 1));
    cyc(0, 1, 1, 0, O_LW, 6'd0, exd(ex("lw_exe", T_EXE, SB_0, 3'b000, 1), 10'b0000_011110));
    cyc(0, 1, 0, 0, O_LW, 6'd0, ex("lw_mem0", T_MEM, SB_LW,  3'b000, 1));
    cyc(0, 1, 0, 0, O_LW, 6'd0, ex("lw_mem1", T_MEM, SB_LW,  3'b000, 1));
    cyc(0, 1, 1, 0, O_LW, 6'd0, ex("lw_mem2", T_MEM, SB_LW,  3'b000, 1));
    cyc(0, 1, 1, 0, O_LW, 6'd0, exd(ex("lw_wb", T_WB, SB_WB, 3'b000, 1), 10'b0000_011110));
    // beq taken / not taken, bne taken / not taken
    cyc(0, 1, 1, 1, O_BEQ, 6'd0, ex("beq1_if", T_IF, SB_IFR, 3'b000, 2));
    cyc(0, 1, 1, 1, O_BEQ, 6'd0, ex("beq1_id", T_ID, SB_0,   3'b000, 2));
    cyc(0, 1, 1, 1, O_BEQ, 6'd0, exd(ex("beq1_exe", T_EXE, SB_BT, 3'b000, 2), 10'b0100_001000));
    cyc(0, 1, 1, 0, O_BEQ, 6'd0, ex("beq0_if", T_IF, SB_IFR, 3'b000, 3));
    cyc(0, 1, 1, 0, O_BEQ, 6'd0, ex("beq0_id", T_ID, SB_0,   3'b000, 3));
    cyc(0, 1, 1, 0, O_BEQ, 6'd0, ex("beq0_exe", T_EXE, SB_BN, 3'b000, 3));
    cyc(0, 1, 1, 0, O_BNE, 6'd0, ex("bne0_if", T_IF, SB_IFR, 3'b000, 4));
    cyc(0, 1, 1, 0, O_BNE, 6'd0, ex("bne0_id", T_ID, SB_0,   3'b000, 4));
    cyc(0, 1, 1, 0, O_BNE, 6'd0, ex("bne0_exe", T_EXE, SB_BT, 3'b000, 4));
    cyc(0, 1, 1, 1, O_BNE, 6'd0, ex("bne1_if", T_IF, SB_IFR, 3'b000, 5));
    cyc(0, 1, 1, 1, O_BNE, 6'd0, ex("bne1_id", T_ID, SB_0,   3'b000, 5));
    cyc(0, 1, 1, 1, O_BNE, 6'd0, ex("bne1_exe", T_EXE, SB_BN, 3'b000, 5));
    // jumps
    cyc(0, 1, 1, 0, O_J,   6'd0, ex("j_if",   T_IF, SB_IFR, 3'b000, 6));
    cyc(0, 1, 1, 0, O_J,   6'd0, ex("j_id",   T_ID, SB_J,   3'b000, 6));
    cyc(0, 1, 1, 0, O_JAL, 6'd0, ex("jal_if", T_IF, SB_IFR, 3'b000, 7));
    cyc(0, 1, 1, 0, O_JAL, 6'd0, exd(ex("jal_id", T_ID, SB_JAL, 3'b000, 7), 10'b0000_000001));
    cyc(0, 1, 1, 0, O_R,   F_JR, ex("jr_if",  T_IF, SB_IFR, 3'b000, 8));
    cyc(0, 1, 1, 0, O_R,   F_JR, ex("jr_id",  T_ID, SB_JR,  3'b000, 8));
    // sw
    cyc(0, 1, 1, 0, O_SW, 6'd0, ex("sw_if",  T_IF,  SB_IFR, 3'b000, 9));
    cyc(0, 1, 1, 0, O_SW, 6'd0, ex("sw_id",  T_ID,  SB_0,   3'b000, 9));
    cyc(0, 1, 1, 0, O_SW, 6'd0, exd(ex("sw_exe", T_EXE, SB_0, 3'b000, 9), 10'b0000_011000));
    cyc(0, 1, 1, 0, O_SW, 6'd0, ex("sw_mem", T_MEM, SB_SW,  3'b000, 9));
    // ori with one IF wait cycle
    cyc(0, 1, 0, 0, O_ORI, 6'd0, ex("ori_ifw", T_IF,  SB_IFW, 3'b000, 10));
    cyc(0, 1, 1, 0, O_ORI, 6'd0, ex("ori_if",  T_IF,  SB_IFR, 3'b000, 10));
    cyc(0, 1, 1, 0, O_ORI, 6'd0, ex("ori_id",  T_ID,  SB_0,   3'b000, 10));
    cyc(0, 1, 1, 0, O_ORI, 6'd0, exd(ex("ori_exe", T_EXE, SB_0, 3'b000, 10), 10'b0101_010100));
    cyc(0, 1, 1, 0, O_ORI, 6'd0, ex("ori_wb",  T_WB,  SB_WB,  3'b000, 10));
    // sra with mem_rdy low outside IF/MEM (must be ignored)
    cyc(0, 1, 1, 0, O_R, F_SRA, ex("sra_if",  T_IF,  SB_IFR, 3'b000, 11));
    cyc(0, 1, 0, 0, O_R, F_SRA, ex("sra_id",  T_ID,  SB_0,   3'b000, 11));
    cyc(0, 1, 0, 0, O_R, F_SRA, exd(ex("sra_exe", T_EXE, SB_0, 3'b000, 11), 10'b1111_100000));
    cyc(0, 1, 0, 0, O_R, F_SRA, ex("sra_wb",  T_WB,  SB_WB,  3'b000, 11));
    // illegal opcode, then reset while halted
    cyc(0, 1, 1, 0, O_BAD, 6'd0, ex("ill_if",   T_IF,   SB_IFR, 3'b000, 12));
    cyc(0, 1, 1, 0, O_BAD, 6'd0, ex("ill_id",   T_ID,   SB_0,   3'b000, 12));
    cyc(0, 1, 1, 0, O_BAD, 6'd0, ex("ill_halt", T_HALT, SB_0,   3'b110, 12));
    cyc(0, 1, 1, 0, O_BAD, 6'd0, ex("ill_hold", T_HALT, SB_0,   3'b110, 12));
    cyc(0, 0, 0, 0, O_R, F_ADD,  ex("ill_rst",  T_IF,   SB_IFW, 3'b000, 0));
    // ready arriving exactly at the wait threshold is accepted
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("thr_w0", T_IF, SB_IFW, 3'b000, 0));
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("thr_w1", T_IF, SB_IFW, 3'b000, 0));
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("thr_w2", T_IF, SB_IFW, 3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("thr_rdy", T_IF, SB_IFR, 3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("thr_id",  T_ID,  SB_0,  3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("thr_exe", T_EXE, SB_0,  3'b000, 0));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("thr_wb",  T_WB,  SB_WB, 3'b000, 0));
    // IF timeout: four unready cycles then HALT with bus_err
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("to_w0", T_IF, SB_IFW, 3'b000, 1));
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("to_w1", T_IF, SB_IFW, 3'b000, 1));
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("to_w2", T_IF, SB_IFW, 3'b000, 1));
    cyc(0, 1, 0, 0, O_R, F_ADD, ex("to_w3", T_IF, SB_IFW, 3'b000, 1));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("to_halt", T_HALT, SB_0, 3'b101, 1));
    cyc(0, 1, 1, 0, O_R, F_ADD, ex("to_hold", T_HALT, SB_0, 3'b101, 1));

    // no-handshake instance: sw in 4 cycles, then wrap the 4-bit counter
    cyc(1, 1, 0, 0, O_SW, 6'd0, ex("nh_sw_if",  T_IF,  SB_IFR, 3'b000, 0));
    cyc(1, 1, 0, 0, O_SW, 6'd0, ex("nh_sw_id",  T_ID,  SB_0,   3'b000, 0));
    cyc(1, 1, 0, 0, O_SW, 6'd0, ex("nh_sw_exe", T_EXE, SB_0,   3'b000, 0));
    cyc(1, 1, 0, 0, O_SW, 6'd0, ex("nh_sw_mem", T_MEM, SB_SW,  3'b000, 0));
    for (int k = 1; k < 16; k++) begin
      cyc(1, 1, 0, 0, O_J, 6'd0, ex("nh_j_if", T_IF, SB_IFR, 3'b000, 32'(k)));
      cyc(1, 1, 0, 0, O_J, 6'd0, ex("nh_j_id", T_ID, SB_J,   3'b000, 32'(k)));
    end
    cyc(1, 1, 0, 0, O_J, 6'd0, ex("nh_wrap", T_IF, SB_IFR, 3'b000, 0));

    repeat (2) @(posedge clock);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
